frame_strobe_gen: RTL and testbench



---
 rtl/frame_strobe_gen.sv | 119 +++++++++++
 tb/tb_frame_strobe_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_strobe_gen.sv
// Column-foot configuration strobe generator: decodes a frame-address word,
// filters it by column and emits a timed one-hot FrameStrobe pulse.
module frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5,
  parameter int Col              = 0,
  parameter int SetupCycles      = 1,
  parameter int StrobeCycles     = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [31:0]                FrameAddr,
  input  logic                       FrameAddrValid,
  output logic                       FrameAddrReady,
  input  logic                       ErrClr,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       FrameDone,
  output logic                       FrameErr,
  output logic                       Busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

  localparam logic [3:0] SetupInit  = 4'(SetupCycles);
  localparam logic [3:0] StrobeInit = 4'(StrobeCycles);

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [FrameSelectWidth-1:0] idx_q, idx_d;
  logic [MaxFramesPerCol-1:0]  strobe_q, strobe_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic [ColSelectWidth-1:0]   col_field;
  logic [FrameSelectWidth-1:0] idx_field;
  logic                        accept, col_hit, idx_ok;

  assign col_field = FrameAddr[31 -: ColSelectWidth];
  assign idx_field = FrameAddr[FrameSelectWidth-1:0];
  assign accept    = FrameAddrValid && FrameAddrReady;
  assign col_hit   = (col_field == ColSelectWidth'(Col));
  assign idx_ok    = (32'(idx_field) < 32'(MaxFramesPerCol));

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (ErrClr) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && col_hit) begin
          if (!idx_ok) begin
            err_d = 1'b1;  // set overrides a simultaneous ErrClr
          end else begin
            idx_d = idx_field;
            if (SetupInit == 4'd0) begin
              state_d = STROBE;
              cnt_d   = StrobeInit;
            end else begin
              state_d = SETUP;
              cnt_d   = SetupInit;
            end
          end
        end
      end
      SETUP: begin
        if (cnt_q <= 4'd1) begin
          state_d = STROBE;
          cnt_d   = StrobeInit;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q <= 4'd1) state_d = GAP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered alongside the state so they align with it exactly.
    strobe_d = '0;
    if (state_d == STROBE) strobe_d = MaxFramesPerCol'(1) << idx_d;
    done_d = (state_d == GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign FrameAddrReady = (state_q == IDLE);
  assign Busy           = (state_q != IDLE);
  assign FrameStrobe    = strobe_q;
  assign FrameDone      = done_q;
  assign FrameErr       = err_q;

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Bench for frame_strobe_gen: two instances (S=1/W=1/Col=0 and S=0/W=3/Col=2)
// checked against a timeline model of accept -> strobe -> done -> ready.
module tb_frame_strobe_gen;
  localparam int NF = 20;

  int s_p   [2] = '{1, 0};
  int w_p   [2] = '{1, 3};
  int col_p [2] = '{0, 2};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr   [2];
  logic          valid  [2];
  logic          clr    [2];
  logic          ready  [2];
  logic          done   [2];
  logic          err    [2];
  logic          busy   [2];
  logic [NF-1:0] strobe [2];

  frame_strobe_gen #(
    .MaxFramesPerCol(NF), .FrameSelectWidth(5), .ColSelectWidth(5),
    .Col(0), .SetupCycles(1), .StrobeCycles(1)
  ) dut_a (
    .CLK(clk), .resetn(rst_n), .FrameAddr(addr[0]), .FrameAddrValid(valid[0]),
    .FrameAddrReady(ready[0]), .ErrClr(clr[0]), .FrameStrobe(strobe[0]),
    .FrameDone(done[0]), .FrameErr(err[0]), .Busy(busy[0])
  );

  frame_strobe_gen #(
    .MaxFramesPerCol(NF), .FrameSelectWidth(5), .ColSelectWidth(5),
    .Col(2), .SetupCycles(0), .StrobeCycles(3)
  ) dut_b (
    .CLK(clk), .resetn(rst_n), .FrameAddr(addr[1]), .FrameAddrValid(valid[1]),
    .FrameAddrReady(ready[1]), .ErrClr(clr[1]), .FrameStrobe(strobe[1]),
    .FrameDone(done[1]), .FrameErr(err[1]), .Busy(busy[1])
  );

  always #5 clk = ~clk;

  // Timeline model: cycle numbers at which each observable event is due.
  int cyc;
  int ready_at [2];
  int str_from [2];
  int str_to   [2];
  int done_at  [2];
  int m_idx    [2];
  bit m_err    [2];
  bit acc_last [2];
  int passed, total;
  int done_cnt, last_start, gap_bad;
  bit prev_hi;

  function automatic logic [31:0] mk(input int col, input int idx, input logic [21:0] junk);
    logic [4:0] c, i;
    c = col[4:0];
    i = idx[4:0];
    return {c, junk, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ready_at[d] = cyc;
      str_from[d] = 1;
      str_to[d]   = 0;
      done_at[d]  = -1;
      m_err[d]    = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [NF-1:0] exp_s;
    bit            exp_r;
    for (int d = 0; d < 2; d++) begin
      exp_s = '0;
      if (cyc >= str_from[d] && cyc <= str_to[d]) exp_s[m_idx[d]] = 1'b1;
      exp_r = (cyc >= ready_at[d]);
      check($sformatf("strobe%0d", d), 32'(strobe[d]), 32'(exp_s));
      check($sformatf("done%0d", d),   32'(done[d]),   32'(cyc == done_at[d]));
      check($sformatf("ready%0d", d),  32'(ready[d]),  32'(exp_r));
      check($sformatf("busy%0d", d),   32'(busy[d]),   32'(!exp_r));
      check($sformatf("err%0d", d),    32'(err[d]),    32'(m_err[d]));
    end
  endtask

  // One clock edge: decide handshakes from the model, advance, then compare.
  task automatic step();
    bit          acc [2];
    bit          c_now [2];
    logic [31:0] a [2];
    for (int d = 0; d < 2; d++) begin
      acc[d]   = valid[d] && (cyc >= ready_at[d]);
      c_now[d] = clr[d];
      a[d]     = addr[d];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      acc_last[d] = acc[d];
      if (c_now[d]) m_err[d] = 1'b0;
      if (acc[d] && int'(a[d][31:27]) == col_p[d]) begin
        if (int'(a[d][4:0]) >= NF) begin
          m_err[d] = 1'b1;
        end else begin
          m_idx[d]    = int'(a[d][4:0]);
          str_from[d] = cyc + s_p[d];
          str_to[d]   = cyc + s_p[d] + w_p[d] - 1;
          done_at[d]  = cyc + s_p[d] + w_p[d];
          ready_at[d] = cyc + s_p[d] + w_p[d] + 1;
        end
      end
    end
    compare_all();
  endtask

  task automatic track_a();
    if (done[0] === 1'b1) done_cnt++;
    if (strobe[0] !== '0 && !prev_hi) begin
      if (cyc - last_start < s_p[0] + w_p[0] + 2) gap_bad++;
      last_start = cyc;
    end
    prev_hi = (strobe[0] !== '0);
  endtask

  initial begin
    int e1, e2, n19;
    passed = 0;
    total  = 0;
    cyc    = 0;
    for (int d = 0; d < 2; d++) begin
      addr[d]  = '0;
      valid[d] = 1'b0;
      clr[d]   = 1'b0;
    end
    model_reset();

    // Reset state
    #1;
    compare_all();
    #12 rst_n = 1'b1;

    // Single in-range frame, S=1 W=1
    addr[0] = 32'h0000_0003; valid[0] = 1'b1;
    step();
    check("t1_accept", 32'(acc_last[0]), 32'd1);
    valid[0] = 1'b0;
    step();
    check("t1_strobe", 32'(strobe[0]), 32'h0000_8);
    step();
    check("t1_done", 32'(done[0]), 32'd1);
    check("t1_ready_low", 32'(ready[0]), 32'd0);
    step();
    check("t1_ready_back", 32'(ready[0]), 32'd1);

    // Other column: consumed silently
    addr[0] = 32'h0800_0005; valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    check("t2_ready", 32'(ready[0]), 32'd1);
    step();
    check("t2_strobe", 32'(strobe[0]), 32'd0);

    // Out-of-range index, clear, and set-beats-clear
    addr[0] = 32'h0000_0014; valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    check("t3_err_set", 32'(err[0]), 32'd1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("t3_err_clr", 32'(err[0]), 32'd0);
    addr[0] = 32'h0000_0015; valid[0] = 1'b1; clr[0] = 1'b1;
    step();
    valid[0] = 1'b0; clr[0] = 1'b0;
    check("t3_set_wins", 32'(err[0]), 32'd1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;

    // S=0 W=3, second word held across the busy period
    addr[1] = mk(2, 19, 22'd0); valid[1] = 1'b1;
    step();
    e1  = cyc;
    n19 = (strobe[1] === 20'h8_0000) ? 1 : 0;
    addr[1] = mk(2, 0, 22'h2a_5a5a);
    acc_last[1] = 1'b0;
    for (int k = 0; k < 10 && !acc_last[1]; k++) begin
      step();
      if (strobe[1] === 20'h8_0000) n19++;
    end
    check("t4_second_accept", 32'(acc_last[1]), 32'd1);
    e2 = cyc;
    valid[1] = 1'b0;
    check("t4_strobe_len", 32'(n19), 32'd3);
    check("t4_period", 32'(e2 - e1), 32'(s_p[1] + w_p[1] + 2));
    check("t4_strobe2", 32'(strobe[1]), 32'h0000_1);
    repeat (5) step();

    // Asynchronous reset in the second strobe cycle
    addr[1] = mk(2, 7, 22'd0); valid[1] = 1'b1;
    step();
    valid[1] = 1'b0;
    step();
    check("t5_mid_strobe", 32'(strobe[1]), 32'h0000_80);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_drop", 32'(strobe[1]), 32'd0);
    check("t5_no_done", 32'(done[1]), 32'd0);
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("t5_ready", 32'(ready[1]), 32'd1);

    // Back-to-back sweep of all indices on instance A
    done_cnt = 0; last_start = -100; gap_bad = 0; prev_hi = 1'b0;
    for (int i = 0; i < NF; i++) begin
      addr[0] = mk(0, i, 22'($urandom));
      valid[0] = 1'b1;
      acc_last[0] = 1'b0;
      for (int k = 0; k < 12 && !acc_last[0]; k++) begin
        step();
        track_a();
      end
      check($sformatf("t6_accept_%0d", i), 32'(acc_last[0]), 32'd1);
    end
    valid[0] = 1'b0;
    repeat (6) begin
      step();
      track_a();
    end
    check("t6_done_count", 32'(done_cnt), 32'(NF));
    check("t6_gap_violations", 32'(gap_bad), 32'd0);

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (cyc >= ready_at[d] || !valid[d]) begin
          valid[d] = ($urandom_range(0, 2) != 0);
          addr[d]  = mk(($urandom_range(0, 3) != 0) ? col_p[d] : int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 23)), 22'($urandom));
        end
        clr[d] = ($urandom_range(0, 9) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
